seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Registered, handshaked successor of the pipeline's combinational EX-stage ALU, parametrised in data width.
- Adds a status-flag register with S-bit gating, ARM-convention carry for subtract ops, and back-pressure on both sides.
- Adds an optional iterative multiply (shift-add) under a compile-time macro.
- Sits in the EX stage between the ID/EX register and the EX/MEM register; the hazard unit stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand and result width in bits; minimum 8.
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block can accept an operation this cycle.
- val1  in  WIDTH  operand 1 (Rn).
- val2  in  WIDTH  operand 2 (shifter output).
- EX_command  in  4  operation code, EX_* encodings from settings.h.
- S  in  1  update SR with this op's flags.
- out_valid  out  1  res/SR valid.
- out_ready  in  1  consumer accepts result.
- res  out  WIDTH  registered result.
- SR  out  4  registered flags {Z,C,N,V}.
- illegal  out  1  result belongs to an unsupported command.

Behaviour:
- Reset values: out_valid=0, res=0, SR=4'b0000, illegal=0, state=IDLE, counter=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation (including during a multiply) aborts the operation and discards its result.
- Handshake:
  - Input accepted on in_valid & in_ready.
  - Output consumed on out_valid & out_ready.
  - in_ready = (state==IDLE) & (~out_valid | out_ready), so accept and drain can happen in the same cycle.
  - res, SR and illegal hold stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: accepting. A single-cycle op accepted at edge N gives out_valid=1 after edge N+1 (latency 1), state stays IDLE. A MUL goes to MUL.
  - MUL: WIDTH iterations, then MUL_DONE.
  - MUL_DONE: loads res and asserts out_valid, then returns to IDLE.
- Carry input to ADC/SBC is the current registered SR C bit; there is no external carry port.
- Arithmetic (C/V written only by the ops listed here):
  - ADD: res=val1+val2; C=carry out of bit WIDTH-1; V=signed overflow.
  - ADC: val1+val2+C, same flag rules as ADD.
  - SUB: val1-val2; C=NOT borrow (val1>=val2 unsigned); V=(sign1!=sign2)&(signR!=sign1).
  - SBC: val1-val2-!C, flag rules as SUB.
  - CMP: as SUB. TST: as AND. For both, SR always updates regardless of S, and res carries the computed value.
  - MOV/MVN/AND/ORR/EOR: C and V preserved; N and Z from the result.
  - LDR: val1+val2. STR: val1+val2 (address add for both). LDR/STR never touch SR.
- Flag definitions: N=res[WIDTH-1]; Z=(res==0). SR updates when the result is registered and (S | CMP | TST).
- Unsupported command: res=0, illegal=1, SR unchanged, latency 1.
- Wrap-around: all results modulo 2^WIDTH.

Optional Feature:
- SEQ_ALU_MUL_EN defined:
  - EX_MUL (new code 4'b1111 in settings.h) runs a shift-add multiply with a CNT_W counter.
  - res = low WIDTH bits of val1*val2; latency WIDTH+1 cycles from accept to out_valid.
  - in_ready=0 throughout. With S set: N and Z update, C and V are preserved.
- Undefined: EX_MUL is treated as unsupported (illegal=1, latency 1). No MUL/MUL_DONE states or counter are synthesised.

Decomposition:
- settings.h holds the EX_* codes including EX_MUL, the SR bit-index constants (SR_Z=3, SR_C=2, SR_N=1, SR_V=0) and state encodings.
- One sub-module, seq_alu_mul, is natural: an iterative multiplier with start/done, instantiated only under SEQ_ALU_MUL_EN.

Test Plan:
- ADD, S=1, 0x7FFFFFFF+0x00000001 -> res=0x80000000, SR={Z0,C0,N1,V1}, out_valid exactly one cycle after accept.
- SUB, S=1, 5-5 -> res=0, SR={1,1,0,0}. Then SBC with C=1, 3-5 -> res=0xFFFFFFFE, C=0, N=1.
- SR C=1, ADC, S=1, 0xFFFFFFFF+0 -> res=0, Z=1, C=1. Then MOV 0 with S=0 -> SR unchanged.
- Back-pressure: ADD 1+2 with out_ready=0 for 3 cycles -> res=3 held, in_ready=0. On the cycle out_ready=1, a new op is accepted the same cycle.
- SEQ_ALU_MUL_EN: MUL 7*6 -> res=42 after 33 cycles, in_ready=0 throughout. MUL 0x10000*0x10000 -> res=0, Z=1 with S=1.
- Assert rst at cycle 10 of a MUL -> next cycle out_valid=0, SR=0, in_ready=1, and no stale result appears. Unsupported code -> illegal=1, res=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: EX command codes, SR bit positions and FSM states shared by seq_alu
package seq_alu_pkg;
    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_MVN = 4'b1001;
    localparam logic [3:0] EX_CMP = 4'b1010;
    localparam logic [3:0] EX_TST = 4'b1011;
    localparam logic [3:0] EX_LDR = 4'b1100;
    localparam logic [3:0] EX_STR = 4'b1101;
    localparam logic [3:0] EX_MUL = 4'b1111;
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_MUL_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, low WIDTH bits of the product, WIDTH iterations
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CNT_W-1:0] r_cnt;
    assign o_done = r_cnt == CNT_W'(1);
    assign o_prod = r_acc;
    // the start edge performs the first iteration so the last one lands WIDTH-1 edges later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a << 1;
            r_b   <= i_b >> 1;
            r_acc <= i_b[0] ? i_a : '0;
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (r_cnt != '0) begin
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_acc <= r_acc + (r_b[0] ? r_a : '0);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered handshaked EX-stage ALU with flag register; SEQ_ALU_MUL_EN adds iterative multiply
module seq_alu import seq_alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       EX_command,
    input  logic             S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       SR,
    output logic             illegal
);
    logic [WIDTH-1:0] r_res, w_b, w_res;
    logic [3:0]       r_sr, w_sr;
    logic             r_illegal, r_out_valid;
    logic [WIDTH:0]   w_sum;
    logic             w_acc, w_drain, w_idle, w_mul;
    logic             w_sub, w_cin, w_cv, w_flag, w_illegal, w_sr_upd;
    assign res       = r_res;
    assign SR        = r_sr;
    assign illegal   = r_illegal;
    assign out_valid = r_out_valid;
    assign in_ready  = w_idle & (~r_out_valid | out_ready);
    assign w_acc     = in_valid & in_ready;
    assign w_drain   = r_out_valid & out_ready;
`ifdef SEQ_ALU_MUL_EN
    state_t           r_state, w_next;
    logic             r_mul_s, w_mul_done;
    logic [WIDTH-1:0] w_prod;
    assign w_mul  = EX_command == EX_MUL;
    assign w_idle = r_state == ST_IDLE;
    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_acc & w_mul),
        .i_a     (val1),
        .i_b     (val2),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
    // next state: IDLE -> MUL on an accepted multiply, MUL -> MUL_DONE on last iteration
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = (w_acc & w_mul) ? ST_MUL : ST_IDLE;
            ST_MUL:  w_next = w_mul_done ? ST_MUL_DONE : ST_MUL;
            default: w_next = ST_IDLE;
        endcase
    end
    // state register and the S bit of the multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mul_s <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc & w_mul) r_mul_s <= S;
        end
    end
`else
    assign w_mul  = 1'b0;
    assign w_idle = 1'b1;
`endif
    // single-cycle datapath: subtracts add the inverted operand, carry-in picks ADC/SBC/SUB behaviour
    always_comb begin
        w_sub     = EX_command == EX_SUB || EX_command == EX_SBC || EX_command == EX_CMP;
        w_b       = w_sub ? ~val2 : val2;
        w_cin     = (EX_command == EX_SUB || EX_command == EX_CMP) ? 1'b1 :
                    (EX_command == EX_ADC || EX_command == EX_SBC) ? r_sr[SR_C] : 1'b0;
        w_sum     = {1'b0, val1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
        w_res     = '0;
        w_illegal = 1'b0;
        w_flag    = 1'b1;
        w_cv      = 1'b0;
        case (EX_command)
            EX_MOV:                                 w_res = val2;
            EX_MVN:                                 w_res = ~val2;
            EX_AND, EX_TST:                         w_res = val1 & val2;
            EX_ORR:                                 w_res = val1 | val2;
            EX_EOR:                                 w_res = val1 ^ val2;
            EX_ADD, EX_ADC, EX_SUB, EX_SBC, EX_CMP: begin
                w_res = w_sum[WIDTH-1:0];
                w_cv  = 1'b1;
            end
            EX_LDR, EX_STR: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = 1'b0;
            end
            default: begin
                w_illegal = 1'b1;
                w_flag    = 1'b0;
            end
        endcase
        w_sr[SR_Z] = w_res == '0;
        w_sr[SR_N] = w_res[WIDTH-1];
        w_sr[SR_C] = w_cv ? w_sum[WIDTH] : r_sr[SR_C];
        w_sr[SR_V] = w_cv ? (val1[WIDTH-1] == w_b[WIDTH-1]) & (w_res[WIDTH-1] != val1[WIDTH-1]) : r_sr[SR_V];
        w_sr_upd   = w_flag & (S | EX_command == EX_CMP | EX_command == EX_TST);
    end
    // output register: load on accept or multiply completion, clear valid on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_sr        <= 4'b0000;
            r_illegal   <= 1'b0;
        end else begin
            if (w_drain) r_out_valid <= 1'b0;
            if (w_acc & ~w_mul) begin
                r_out_valid <= 1'b1;
                r_res       <= w_res;
                r_illegal   <= w_illegal;
                if (w_sr_upd) r_sr <= w_sr;
            end
`ifdef SEQ_ALU_MUL_EN
            if (r_state == ST_MUL_DONE) begin
                r_out_valid <= 1'b1;
                r_res       <= w_prod;
                r_illegal   <= 1'b0;
                if (r_mul_s) r_sr <= {w_prod == '0, r_sr[SR_C], w_prod[WIDTH-1], r_sr[SR_V]};
            end
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
    import seq_alu_pkg::*;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  sr;
        logic        ill;
    } exp_t;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    logic        clk, rst, in_valid, in_ready, S, out_valid, out_ready, illegal;
    logic [31:0] val1, val2, res;
    logic [3:0]  EX_command, SR;
    exp_t        q[$];
    logic [3:0]  m_sr;
    int          checks, failures, last_wait;
    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .val1       (val1),
        .val2       (val2),
        .EX_command (EX_command),
        .S          (S),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res        (res),
        .SR         (SR),
        .illegal    (illegal)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    // reference: plain 64-bit arithmetic on the operand values, flags from value ranges
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint ua, ub, sa, sb, u, v;
        logic   ci, arith, flags, subop;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = m_sr[SR_C];
        arith = 1'b0;
        flags = 1'b1;
        subop = c == EX_SUB || c == EX_SBC || c == EX_CMP;
        u = 0;
        v = 0;
        e.ill = 1'b0;
        case (c)
            EX_ADD:         begin u = ua + ub; v = sa + sb; arith = 1'b1; end
            EX_ADC:         begin u = ua + ub + longint'(ci); v = sa + sb + longint'(ci); arith = 1'b1; end
            EX_SUB, EX_CMP: begin u = ua - ub; v = sa - sb; arith = 1'b1; end
            EX_SBC:         begin u = ua - ub - longint'(!ci); v = sa - sb - longint'(!ci); arith = 1'b1; end
            EX_LDR, EX_STR: begin u = ua + ub; flags = 1'b0; end
            EX_MOV:         u = ub;
            EX_MVN:         u = longint'({32'b0, ~b});
            EX_AND, EX_TST: u = ua & ub;
            EX_ORR:         u = ua | ub;
            EX_EOR:         u = ua ^ ub;
`ifdef SEQ_ALU_MUL_EN
            EX_MUL:         u = ua * ub;
`endif
            default:        begin e.ill = 1'b1; flags = 1'b0; end
        endcase
        e.res = e.ill ? 32'h0 : u[31:0];
        e.sr = m_sr;
        if (flags && (s || c == EX_CMP || c == EX_TST)) begin
            e.sr[SR_Z] = e.res == 32'h0;
            e.sr[SR_N] = e.res[31];
            if (arith) begin
                e.sr[SR_C] = subop ? (u >= 0) : (u >= 64'sh1_0000_0000);
                e.sr[SR_V] = (v > SMAX) || (v < SMIN);
            end
        end
        m_sr = e.sr;
        q.push_back(e);
    endtask
    // issue one op; expectation is queued at the negedge before the accepting edge
    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic s, input bit rnd);
        EX_command = c;
        val1 = a;
        val2 = b;
        S = s;
        in_valid = 1'b1;
        last_wait = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            last_wait++;
            if (last_wait > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
            step;
            if (rnd) out_ready = ($urandom % 4) != 0;
        end
        model(c, a, b, s);
        step;
        in_valid = 1'b0;
        if (rnd) out_ready = ($urandom % 4) != 0;
    endtask
    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction
    // monitor: compares every consumed result against the queue and checks stability under stall
    initial begin
        exp_t        e;
        logic        hold;
        logic [36:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                checks++;
                if (!out_valid || {res, SR, illegal} !== held) begin
                    failures++;
                    $display("FAIL hold got=%b/%h exp=1/%h", out_valid, {res, SR, illegal}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got=%h exp=none", {res, SR, illegal});
                end else begin
                    e = q.pop_front();
                    if ({res, SR, illegal} !== {e.res, e.sr, e.ill}) begin
                        failures++;
                        $display("FAIL result got res=%h sr=%b ill=%b exp res=%h sr=%b ill=%b",
                                 res, SR, illegal, e.res, e.sr, e.ill);
                    end
                end
            end
            hold = out_valid && !out_ready;
            held = {res, SR, illegal};
        end
    end
    initial begin
        int  n;
        bit  ok, stale;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        val1 = '0;
        val2 = '0;
        EX_command = '0;
        S = 1'b0;
        m_sr = 4'b0000;
        checks = 0;
        failures = 0;
        repeat (3) step;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_sr", 32'(SR), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step;
        out_ready = 1'b1;
        op(EX_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 0);
        @(negedge clk);
        chk("add_latency", 32'(out_valid), 32'd1);
        chk("add_res", res, 32'h80000000);
        chk("add_sr", 32'(SR), 32'b0011);
        step;
        op(EX_SUB, 32'd5, 32'd5, 1'b1, 0);
        @(negedge clk);
        chk("sub_sr", 32'(SR), 32'b1100);
        step;
        op(EX_SBC, 32'd3, 32'd5, 1'b1, 0);
        @(negedge clk);
        chk("sbc_res", res, 32'hFFFFFFFE);
        chk("sbc_sr", 32'(SR), 32'b0010);
        step;
        op(EX_CMP, 32'd5, 32'd5, 1'b0, 0);
        op(EX_ADC, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        @(negedge clk);
        chk("adc_res", res, 32'h0);
        chk("adc_sr", 32'(SR), 32'b1100);
        step;
        op(EX_MVN, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        chk("mvn_nos_res", res, 32'hFFFFFFFF);
        chk("mvn_nos_sr", 32'(SR), 32'b1100);
        step;
        out_ready = 1'b0;
        op(EX_ADD, 32'd1, 32'd2, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res", res, 32'd3);
        end
        step;
        out_ready = 1'b1;
        op(EX_ADD, 32'd4, 32'd4, 1'b0, 0);
        chk("bp_same_cycle_accept", 32'(last_wait), 32'd0);
        op(4'b1110, 32'd5, 32'd6, 1'b1, 0);
        @(negedge clk);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_res", res, 32'd0);
        step;
`ifdef SEQ_ALU_MUL_EN
        op(EX_MUL, 32'd7, 32'd6, 1'b0, 0);
        ok = 1'b1;
        for (n = 1; n < 60; n++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) ok = 1'b0;
        end
        chk("mul_latency", 32'(n), 32'd33);
        chk("mul_in_ready_low", 32'(ok), 32'd1);
        chk("mul_res", res, 32'd42);
        step;
        op(EX_MUL, 32'h10000, 32'h10000, 1'b1, 0);
        repeat (33) @(negedge clk);
        chk("mul_wrap_res", res, 32'd0);
        chk("mul_wrap_z", 32'(SR[SR_Z]), 32'd1);
        step;
`else
        op(EX_MUL, 32'd7, 32'd6, 1'b1, 0);
        @(negedge clk);
        chk("mul_off_illegal", 32'(illegal), 32'd1);
        chk("mul_off_res", res, 32'd0);
        step;
`endif
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) begin
                step;
                out_ready = ($urandom % 4) != 0;
            end
            op(4'($urandom % 16), pick(), pick(), 1'($urandom % 2), 1);
        end
        out_ready = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
        end
        chk("drain", 32'(q.size()), 32'd0);
        step;
`ifdef SEQ_ALU_MUL_EN
        op(EX_MUL, 32'd9, 32'd9, 1'b1, 0);
`else
        out_ready = 1'b0;
        op(EX_ADD, 32'd9, 32'd9, 1'b1, 0);
`endif
        repeat (9) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        q.delete();
        m_sr = 4'b0000;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sr", 32'(SR), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        step;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", 32'(stale), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
